// File: rtl/stop_watch_pkg.sv
// rtl/stop_watch_pkg.sv - shared types and constants for the stop-watch button conditioner
package stop_watch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int unsigned SYS_CLK_HZ       = 50_000_000;
  // 10 ms of stable level at the system clock
  localparam int unsigned DEBOUNCE_CYC_DEF = SYS_CLK_HZ / 100;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button: 2-flop synchroniser, polarity fix, press/release debounce FSM
module btn_debounce
  import stop_watch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC   = DEBOUNCE_CYC_DEF,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o,
  output logic held_o
);

  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic           REL_LVL  = BTN_ACTIVE_LOW;

  logic [1:0]    sync_q;
  logic          p;
  btn_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc_d;
  logic          press_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {2{REL_LVL}};
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  // Pin equal to the released level means not pressed, whatever the polarity
  assign p         = sync_q[1] ^ REL_LVL;
  assign cnt_inc_d = cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (p) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!p) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        PRESSED: begin
          if (!p) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (p) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign press_o = press_q;
  assign held_o  = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/stop_watch_btn_cond.sv
// rtl/stop_watch_btn_cond.sv - two debounced buttons, stop-over-start priority, registered command pulses
module stop_watch_btn_cond
  import stop_watch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC   = DEBOUNCE_CYC_DEF,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_pause,
  input  logic       btn_stop,
  output logic       o_start_pause,
  output logic       o_stop,
  output logic [1:0] o_held
);

  logic press_sp, press_st;
  logic held_sp, held_st;
  logic sp_d, stop_d;
  logic sp_q, stop_q;
  logic [1:0] held_d, held_q;

  btn_debounce #(
    .DEBOUNCE_CYC  (DEBOUNCE_CYC),
    .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
  ) u_db_start_pause (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_start_pause),
    .press_o(press_sp),
    .held_o (held_sp)
  );

  btn_debounce #(
    .DEBOUNCE_CYC  (DEBOUNCE_CYC),
    .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
  ) u_db_stop (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_stop),
    .press_o(press_st),
    .held_o (held_st)
  );

  // A stop confirmed in the same cycle swallows the start/pause press for good
  assign stop_d = press_st;
  assign sp_d   = press_sp & ~press_st;
  assign held_d = {held_st, held_sp};

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q   <= 1'b0;
      stop_q <= 1'b0;
      held_q <= 2'b00;
    end else begin
      sp_q   <= sp_d;
      stop_q <= stop_d;
      held_q <= held_d;
    end
  end

  assign o_start_pause = sp_q;
  assign o_stop        = stop_q;
  assign o_held        = held_q;

endmodule

// File: tb/tb_stop_watch_btn_cond.sv
// tb/tb_stop_watch_btn_cond.sv - scoreboard bench with a run-length reference model of the button conditioner
module tb_stop_watch_btn_cond;

  localparam int D   = 4;
  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start_pause = 1'b1;
  logic       btn_stop = 1'b1;
  logic       o_start_pause;
  logic       o_stop;
  logic [1:0] o_held;

  stop_watch_btn_cond #(
    .DEBOUNCE_CYC  (D),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_start_pause(btn_start_pause),
    .btn_stop       (btn_stop),
    .o_start_pause  (o_start_pause),
    .o_stop         (o_stop),
    .o_held         (o_held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: a button's confirmed level flips once the opposite level
  // has been seen for D+1 consecutive samples; outputs follow LAT edges later.
  bit       conf[2];
  bit       run_lvl[2];
  int       run_len[2];
  bit [1:0] exp_held[256];
  int       q_sp[$];
  int       q_st[$];
  bit       mon_en = 1'b0;

  task automatic model_sample();
    int c;
    bit p [2];
    bit ev[2];
    c = cyc;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        conf[b] = 1'b0; run_lvl[b] = 1'b0; run_len[b] = 0;
      end
      for (int i = 0; i <= LAT; i++) exp_held[(c + i) % 256] = 2'b00;
      while (q_sp.size() > 0 && q_sp[$] >= c) void'(q_sp.pop_back());
      while (q_st.size() > 0 && q_st[$] >= c) void'(q_st.pop_back());
      mon_en = 1'b1;
    end else begin
      p[0] = (btn_start_pause == 1'b0);
      p[1] = (btn_stop == 1'b0);
      for (int b = 0; b < 2; b++) begin
        ev[b] = 1'b0;
        if (p[b] == run_lvl[b]) begin
          if (run_len[b] < 100000) run_len[b]++;
        end else begin
          run_lvl[b] = p[b];
          run_len[b] = 1;
        end
        if (p[b] != conf[b] && run_len[b] == D + 1) begin
          conf[b] = p[b];
          ev[b]   = p[b];
        end
      end
      exp_held[(c + LAT) % 256] = {conf[1], conf[0]};
      if (ev[1]) q_st.push_back(c + LAT);
      else if (ev[0]) q_sp.push_back(c + LAT);
    end
  endtask

  task automatic drive(input bit sp, input bit st, input int n, input bit r = 1'b0);
    repeat (n) begin
      @(negedge clk);
      model_sample();
      rst             = r;
      btn_start_pause = ~sp;
      btn_stop        = ~st;
    end
  endtask

  bit e_sp, e_st;
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      e_sp = (q_sp.size() > 0 && q_sp[0] == cyc);
      e_st = (q_st.size() > 0 && q_st[0] == cyc);
      if (e_sp) void'(q_sp.pop_front());
      if (e_st) void'(q_st.pop_front());
      check("o_start_pause", int'(o_start_pause), int'(e_sp));
      check("o_stop", int'(o_stop), int'(e_st));
      check("o_held", int'(o_held), int'(exp_held[cyc % 256]));
    end
  end

  int  rem_sp = 0, rem_st = 0;
  bit  lvl_sp = 1'b0, lvl_st = 1'b0;
  bit  rnd_rst;

  initial begin
    drive(0, 0, 3, 1'b1);
    // clean press and release
    drive(1, 0, 20);
    drive(0, 0, 15);
    // press bounce, then a stable press
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 2);
      drive(0, 0, 2);
    end
    drive(0, 0, 10);
    drive(1, 0, 10);
    drive(0, 0, 15);
    // release bounce
    drive(1, 0, 12);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1);
      drive(1, 0, 1);
    end
    drive(0, 0, 15);
    // simultaneous press
    drive(1, 1, 20);
    drive(0, 0, 15);
    // reset during press wait with the pin still low
    drive(1, 0, 3);
    drive(1, 0, 2, 1'b1);
    drive(1, 0, 15);
    drive(0, 0, 15);
    // long hold, then a second press
    drive(1, 0, 200);
    drive(0, 0, 15);
    drive(1, 0, 10);
    drive(0, 0, 15);
    // random independent bouncing on both pins, rare resets
    for (int i = 0; i < 1500; i++) begin
      if (rem_sp <= 0) begin
        lvl_sp = ~lvl_sp;
        rem_sp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 14));
      end
      if (rem_st <= 0) begin
        lvl_st = ~lvl_st;
        rem_st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 14));
      end
      rnd_rst = ($urandom_range(0, 299) == 0);
      drive(lvl_sp, lvl_st, 1, rnd_rst);
      rem_sp--;
      rem_st--;
    end
    drive(0, 0, 20);
    check("start_pause_queue_drained", q_sp.size(), 0);
    check("stop_queue_drained", q_st.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
